// File: rtl/seq_divider_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the sequential restoring divider slice:
//   - DEFAULT_WIDTH : default operand/result width
//   - MAX_WIDTH     : widest operand the magnitude helper can handle
//   - state_t       : FSM state encoding (IDLE=0, CALC=1, FIX=2, DONE=3)
//   - magnitude()   : two's-complement magnitude / conditional negation
// -----------------------------------------------------------------------------
package div_pkg;

  localparam int DEFAULT_WIDTH = 6;
  localparam int MAX_WIDTH     = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Negates the value when 'negative' is set, otherwise passes it through.
  // Callers zero-extend a narrower operand and keep only its low bits, which
  // yields the true magnitude even for the most-negative value.
  function automatic logic [MAX_WIDTH-1:0] magnitude(input logic [MAX_WIDTH-1:0] value,
                                                     input logic                 negative);
    return negative ? (~value + 1'b1) : value;
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// -----------------------------------------------------------------------------
// seq_divider_if
// Request/response bundle of the sequential divider.
//   start, dividend, divisor          : requester -> divider
//   busy, done, quotient, remainder,
//   dbz, ovf                          : divider -> requester
// Modports: master (requester side), slave (divider side).
// -----------------------------------------------------------------------------
interface seq_divider_if
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             dbz;
  logic             ovf;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, dbz, ovf
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, dbz, ovf
  );

endinterface

// File: rtl/seq_divider_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational radix-2 restoring iteration.
//   p_in        : partial remainder before the step (WIDTH+1 bits)
//   next_bit    : next dividend-magnitude bit, MSB first
//   divisor_mag : divisor magnitude
//   p_out       : partial remainder after the step
//   q_bit       : quotient bit produced by the step
// -----------------------------------------------------------------------------
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH:0]   p_in,
  input  logic             next_bit,
  input  logic [WIDTH-1:0] divisor_mag,
  output logic [WIDTH:0]   p_out,
  output logic             q_bit
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;

  // The trial subtraction is one bit wider than P so its MSB is a clean sign:
  // a set MSB means the shifted remainder was smaller than the divisor and the
  // step restores (keeps) the shifted value.
  always_comb begin
    shifted = {p_in, next_bit};
    trial   = shifted - {2'b00, divisor_mag};
    q_bit   = ~trial[WIDTH+1];
    p_out   = q_bit ? trial[WIDTH:0] : shifted[WIDTH:0];
  end

endmodule

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Sequential radix-2 restoring divider, one quotient bit per clock, truncating
// quotient and remainder (remainder takes the dividend's sign).
//   clk    : rising-edge clock
//   reset  : synchronous, active-high
//   bus    : seq_divider_if.slave
//            start/dividend/divisor in; busy, done (1-cycle pulse), quotient,
//            remainder, dbz (divide by zero), ovf (most-negative / -1) out
// Parameters: WIDTH (>=2), SIGNED (1 = two's complement, 0 = unsigned).
// Latency: WIDTH+2 cycles from start to done, 2 cycles on divide by zero.
// -----------------------------------------------------------------------------
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter bit SIGNED = 1'b1
) (
  input logic           clk,
  input logic           reset,
  seq_divider_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           state;
  state_t           state_next;
  logic             accept;

  logic [CNT_W-1:0] count;
  logic [WIDTH:0]   part_rem;
  logic [WIDTH-1:0] dvd_shift;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] q_mag;
  logic [WIDTH-1:0] dvd_raw;
  logic             sign_n;
  logic             sign_d;
  logic             dbz_pend;
  logic             ovf_pend;

  logic             dvd_neg_in;
  logic             dvs_neg_in;
  logic [WIDTH-1:0] dvd_mag_in;
  logic [WIDTH-1:0] dvs_mag_in;

  logic [WIDTH:0]   step_rem;
  logic             step_q;

  logic [WIDTH-1:0] quotient_r;
  logic [WIDTH-1:0] remainder_r;
  logic             dbz_r;
  logic             ovf_r;

  // In unsigned mode the sign bits are forced to zero so magnitudes are the
  // raw operands.
  assign dvd_neg_in = SIGNED & bus.dividend[WIDTH-1];
  assign dvs_neg_in = SIGNED & bus.divisor[WIDTH-1];
  assign dvd_mag_in = WIDTH'(magnitude(MAX_WIDTH'(bus.dividend), dvd_neg_in));
  assign dvs_mag_in = WIDTH'(magnitude(MAX_WIDTH'(bus.divisor), dvs_neg_in));

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .p_in        (part_rem),
    .next_bit    (dvd_shift[WIDTH-1]),
    .divisor_mag (dvs_mag),
    .p_out       (step_rem),
    .q_bit       (step_q)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. A start is only honoured in IDLE or DONE, which lets a
  // held start chain operations with no idle gap; a zero divisor skips the
  // iterations entirely.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: accept = bus.start;
      CALC: begin
        if (count == CNT_W'(WIDTH - 1)) begin
          state_next = FIX;
        end
      end
      FIX:  state_next = DONE;
      DONE: begin
        state_next = IDLE;
        accept     = bus.start;
      end
      default: state_next = IDLE;
    endcase
    if (accept) begin
      state_next = (bus.divisor == '0) ? FIX : CALC;
    end
  end

  // Datapath: capture operands on accept, then run one restoring step per
  // CALC cycle, shifting dividend bits out MSB first and quotient bits in.
  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= '0;
      part_rem  <= '0;
      dvd_shift <= '0;
      dvs_mag   <= '0;
      q_mag     <= '0;
      dvd_raw   <= '0;
      sign_n    <= 1'b0;
      sign_d    <= 1'b0;
      dbz_pend  <= 1'b0;
      ovf_pend  <= 1'b0;
    end else if (accept) begin
      count     <= '0;
      part_rem  <= '0;
      dvd_shift <= dvd_mag_in;
      dvs_mag   <= dvs_mag_in;
      q_mag     <= '0;
      dvd_raw   <= bus.dividend;
      sign_n    <= dvd_neg_in;
      sign_d    <= dvs_neg_in;
      dbz_pend  <= (bus.divisor == '0);
      ovf_pend  <= SIGNED && (bus.dividend == {1'b1, {(WIDTH-1){1'b0}}})
                          && (bus.divisor == '1);
    end else if (state == CALC) begin
      part_rem  <= step_rem;
      dvd_shift <= dvd_shift << 1;
      q_mag     <= {q_mag[WIDTH-2:0], step_q};
      count     <= count + 1'b1;
    end
  end

  // Result registers: flags clear on a new accept, everything is loaded in
  // FIX and then held until the next FIX. Special cases take priority over
  // the sign fix-up of the iterated magnitudes.
  always_ff @(posedge clk) begin
    if (reset) begin
      quotient_r  <= '0;
      remainder_r <= '0;
      dbz_r       <= 1'b0;
      ovf_r       <= 1'b0;
    end else if (accept) begin
      dbz_r <= 1'b0;
      ovf_r <= 1'b0;
    end else if (state == FIX) begin
      if (dbz_pend) begin
        quotient_r  <= '1;
        remainder_r <= dvd_raw;
        dbz_r       <= 1'b1;
      end else if (ovf_pend) begin
        quotient_r  <= {1'b1, {(WIDTH-1){1'b0}}};
        remainder_r <= '0;
        ovf_r       <= 1'b1;
      end else begin
        quotient_r  <= WIDTH'(magnitude(MAX_WIDTH'(q_mag), sign_n ^ sign_d));
        remainder_r <= WIDTH'(magnitude(MAX_WIDTH'(part_rem[WIDTH-1:0]), sign_n));
      end
    end
  end

  assign bus.busy      = (state == CALC) || (state == FIX);
  assign bus.done      = (state == DONE);
  assign bus.quotient  = quotient_r;
  assign bus.remainder = remainder_r;
  assign bus.dbz       = dbz_r;
  assign bus.ovf       = ovf_r;

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
// Scoreboard bench for seq_divider: a signed and an unsigned instance (WIDTH=6)
// share clock and reset. Each issued operation pushes its expected result,
// done cycle and busy length into a per-instance queue; a monitor per instance
// pops and compares whenever done is seen. Expected values come from plain
// integer division with the truncating rules and special cases of the divider.
// -----------------------------------------------------------------------------
module tb_seq_divider;
  import div_pkg::*;

  localparam int W = 6;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    logic         ovf;
    int           done_cyc;
    int           busy_cycles;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   compared;
  int   mismatched;
  int   s_busy_cnt;
  int   u_busy_cnt;
  exp_t s_exp[$];
  exp_t u_exp[$];

  seq_divider_if #(.WIDTH(W)) s_bus ();
  seq_divider_if #(.WIDTH(W)) u_bus ();

  seq_divider #(.WIDTH(W), .SIGNED(1'b1)) u_dut_s (
    .clk   (clk),
    .reset (reset),
    .bus   (s_bus)
  );

  seq_divider #(.WIDTH(W), .SIGNED(1'b0)) u_dut_u (
    .clk   (clk),
    .reset (reset),
    .bus   (u_bus)
  );

  // Free-running clock and an edge counter used for latency checks.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Hard stop in case something wedges outside the bounded waits.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Reference: truncating integer division with the divide-by-zero and
  // signed-overflow conventions.
  function automatic exp_t model(input bit is_signed, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input int now);
    exp_t e;
    int   sa;
    int   sb;
    if (is_signed) begin
      sa = int'($signed(a));
      sb = int'($signed(b));
    end else begin
      sa = int'(a);
      sb = int'(b);
    end
    e.dbz = 1'b0;
    e.ovf = 1'b0;
    if (sb == 0) begin
      e.q   = '1;
      e.r   = a;
      e.dbz = 1'b1;
    end else if (is_signed && sa == -(2 ** (W - 1)) && sb == -1) begin
      e.q   = W'(-(2 ** (W - 1)));
      e.r   = '0;
      e.ovf = 1'b1;
    end else begin
      e.q = W'(sa / sb);
      e.r = W'(sa % sb);
    end
    e.done_cyc    = now + ((sb == 0) ? 2 : W + 2);
    e.busy_cycles = (sb == 0) ? 1 : W + 1;
    return e;
  endfunction

  task automatic waitIdle(input bit sel);
    int guard;
    guard = 0;
    while ((sel ? u_bus.busy : s_bus.busy) && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    checkOutput(sel ? "u_idle_before_start" : "s_idle_before_start",
                int'(sel ? u_bus.busy : s_bus.busy), 0);
  endtask

  // Issues one operation as a single-cycle start pulse (sel: 0 signed, 1 unsigned).
  task automatic applyStimulus(input bit sel, input logic [W-1:0] a, input logic [W-1:0] b);
    waitIdle(sel);
    if (sel) begin
      u_bus.start    = 1'b1;
      u_bus.dividend = a;
      u_bus.divisor  = b;
      u_exp.push_back(model(1'b0, a, b, cyc));
    end else begin
      s_bus.start    = 1'b1;
      s_bus.dividend = a;
      s_bus.divisor  = b;
      s_exp.push_back(model(1'b1, a, b, cyc));
    end
    @(negedge clk);
    s_bus.start = 1'b0;
    u_bus.start = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((s_exp.size() != 0 || u_exp.size() != 0) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("s_pending_results", s_exp.size(), 0);
    checkOutput("u_pending_results", u_exp.size(), 0);
  endtask

  // Monitor for the signed instance.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      s_busy_cnt = 0;
    end else begin
      if (s_bus.busy) s_busy_cnt++;
      if (s_bus.done) begin
        checkOutput("s_done_expected", int'(s_exp.size() != 0), 1);
        if (s_exp.size() != 0) begin
          e = s_exp.pop_front();
          checkOutput("s_quotient", int'(s_bus.quotient), int'(e.q));
          checkOutput("s_remainder", int'(s_bus.remainder), int'(e.r));
          checkOutput("s_dbz", int'(s_bus.dbz), int'(e.dbz));
          checkOutput("s_ovf", int'(s_bus.ovf), int'(e.ovf));
          checkOutput("s_done_cycle", cyc, e.done_cyc);
          checkOutput("s_busy_cycles", s_busy_cnt, e.busy_cycles);
          checkOutput("s_busy_in_done", int'(s_bus.busy), 0);
        end
        s_busy_cnt = 0;
      end
    end
  end

  // Monitor for the unsigned instance.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      u_busy_cnt = 0;
    end else begin
      if (u_bus.busy) u_busy_cnt++;
      if (u_bus.done) begin
        checkOutput("u_done_expected", int'(u_exp.size() != 0), 1);
        if (u_exp.size() != 0) begin
          e = u_exp.pop_front();
          checkOutput("u_quotient", int'(u_bus.quotient), int'(e.q));
          checkOutput("u_remainder", int'(u_bus.remainder), int'(e.r));
          checkOutput("u_dbz", int'(u_bus.dbz), int'(e.dbz));
          checkOutput("u_done_cycle", cyc, e.done_cyc);
          checkOutput("u_busy_cycles", u_busy_cnt, e.busy_cycles);
        end
        u_busy_cnt = 0;
      end
    end
  end

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           pick;

    compared       = 0;
    mismatched     = 0;
    s_busy_cnt     = 0;
    u_busy_cnt     = 0;
    reset          = 1'b1;
    s_bus.start    = 1'b0;
    s_bus.dividend = '0;
    s_bus.divisor  = '0;
    u_bus.start    = 1'b0;
    u_bus.dividend = '0;
    u_bus.divisor  = '0;
    $display("[TB] start");

    repeat (3) @(negedge clk);
    checkOutput("reset_busy", int'(s_bus.busy), 0);
    checkOutput("reset_done", int'(s_bus.done), 0);
    checkOutput("reset_quotient", int'(s_bus.quotient), 0);
    checkOutput("reset_remainder", int'(s_bus.remainder), 0);
    checkOutput("reset_dbz", int'(s_bus.dbz), 0);
    checkOutput("reset_ovf", int'(s_bus.ovf), 0);
    checkOutput("reset_u_quotient", int'(u_bus.quotient), 0);
    reset = 1'b0;
    @(negedge clk);

    // Directed signed cases, including divide by zero and overflow.
    applyStimulus(1'b0, 6'd27, 6'd5);
    applyStimulus(1'b0, W'(-27), 6'd5);
    applyStimulus(1'b0, 6'd27, W'(-5));
    applyStimulus(1'b0, W'(-27), W'(-5));
    applyStimulus(1'b0, 6'd13, 6'd0);
    applyStimulus(1'b0, 6'd27, 6'd5);
    applyStimulus(1'b0, 6'b100000, W'(-1));
    applyStimulus(1'b0, 6'b100000, 6'd5);
    applyStimulus(1'b0, 6'd31, 6'b100000);

    // Directed unsigned cases.
    applyStimulus(1'b1, 6'd63, 6'd7);
    applyStimulus(1'b1, 6'd5, 6'd9);
    applyStimulus(1'b1, 6'd63, 6'd1);
    applyStimulus(1'b1, 6'd40, 6'd0);
    drain();

    // Second start pulses during an operation must be ignored.
    applyStimulus(1'b0, 6'd30, 6'd7);
    @(negedge clk);
    s_bus.start = 1'b1; s_bus.dividend = 6'd1; s_bus.divisor = 6'd1;
    @(negedge clk);
    s_bus.start = 1'b0;
    @(negedge clk);
    s_bus.start = 1'b1;
    @(negedge clk);
    s_bus.start = 1'b0;
    drain();

    // Start held high through DONE chains a second operation.
    waitIdle(1'b0);
    s_bus.start    = 1'b1;
    s_bus.dividend = 6'd27;
    s_bus.divisor  = 6'd5;
    s_exp.push_back(model(1'b1, 6'd27, 6'd5, cyc));
    @(negedge clk);
    waitIdle(1'b0);
    s_bus.dividend = W'(-27);
    s_bus.divisor  = W'(-5);
    s_exp.push_back(model(1'b1, W'(-27), W'(-5), cyc));
    @(negedge clk);
    s_bus.start = 1'b0;
    drain();

    // Randomized operands on both instances.
    for (int i = 0; i < 40; i++) begin
      a    = W'($urandom_range(0, 63));
      b    = W'($urandom_range(0, 63));
      pick = int'($urandom_range(0, 9));
      if (pick == 0) b = '0;
      if (pick == 1) b = '1;
      if (pick == 2) a = 6'b100000;
      applyStimulus(1'b0, a, b);
    end
    for (int i = 0; i < 20; i++) begin
      a = W'($urandom_range(0, 63));
      b = W'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) b = '0;
      applyStimulus(1'b1, a, b);
    end
    drain();

    // Reset in CALC cycle 4 aborts without a done pulse; reset beats a
    // simultaneous start.
    waitIdle(1'b0);
    s_bus.start    = 1'b1;
    s_bus.dividend = 6'd27;
    s_bus.divisor  = 6'd5;
    @(negedge clk);
    s_bus.start = 1'b0;
    repeat (3) @(negedge clk);
    reset       = 1'b1;
    s_bus.start = 1'b1;
    @(negedge clk);
    checkOutput("abort_busy", int'(s_bus.busy), 0);
    checkOutput("abort_done", int'(s_bus.done), 0);
    checkOutput("abort_quotient", int'(s_bus.quotient), 0);
    checkOutput("abort_remainder", int'(s_bus.remainder), 0);
    checkOutput("abort_dbz", int'(s_bus.dbz), 0);
    checkOutput("abort_ovf", int'(s_bus.ovf), 0);
    s_bus.start = 1'b0;
    reset       = 1'b0;
    repeat (12) @(negedge clk);
    checkOutput("abort_stays_idle", int'(s_bus.busy), 0);
    applyStimulus(1'b0, W'(-27), 6'd5);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
# seq_divider

Sequential radix-2 restoring divider: the division counterpart to the team's Booth multiplier datapath. It accepts a dividend/divisor pair on a start strobe, iterates one quotient bit per clock, and returns a truncating quotient and remainder with a one-cycle done pulse. Its handshake style and operand widths match the multiplier, so an ALU wrapper can mux either unit.

## Interface
- WIDTH, 6, operand, quotient and remainder width in bits (≥2)
- SIGNED, 1, 1 = two's-complement operands and results; 0 = unsigned
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  request; sampled only when busy=0
- dividend  in  WIDTH  captured on accepted start
- divisor  in  WIDTH  captured on accepted start
- busy  out  1  high from the cycle after accept until done
- done  out  1  one-cycle pulse; results valid from this cycle
- quotient  out  WIDTH  registered result
- remainder  out  WIDTH  registered result
- dbz  out  1  divide-by-zero flag for the last operation
- ovf  out  1  signed overflow flag (most-negative ÷ −1)

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE/DONE + start: capture signs and magnitudes (SIGNED=0: magnitude = operand, signs = 0). Clear the step counter. If divisor == 0, go to FIX; otherwise go to CALC.
- CALC: WIDTH iterations, MSB first, one per cycle. Partial remainder P (WIDTH+1 bits) shifts left, taking the next dividend-magnitude bit. T = P − |divisor|. If T ≥ 0 then P = T and the q bit is 1; else P is kept and the q bit is 0. After WIDTH iterations go to FIX.
- FIX: register the outputs, then go to DONE.
  - Normal: quotient = negated magnitude if sign(dividend) ≠ sign(divisor); remainder takes the dividend's sign (truncation: dividend = q·divisor + r, |r| < |divisor|).
  - dbz: quotient = all ones, remainder = dividend, dbz = 1.
  - ovf (SIGNED, dividend = −2^(WIDTH−1), divisor = −1): quotient = −2^(WIDTH−1), remainder = 0, ovf = 1.
- DONE: done = 1 for this cycle only. Then go to IDLE, or accept a new start in the same cycle.
- Outputs hold until the next FIX. dbz and ovf clear when the next start is accepted.
- start while busy = 1 is ignored; no queueing.

## Timing
- Reset: state IDLE; busy, done, dbz, ovf = 0; quotient and remainder = 0. Reset mid-operation aborts with no done pulse.
- Start accepted at edge n. busy = 1 during cycles n+1 … n+WIDTH+1. done = 1 and busy = 0 in cycle n+WIDTH+2, so latency is WIDTH+2 cycles (8 for WIDTH=6).
- dbz path: FIX in cycle n+1, done in cycle n+2.
- Back-to-back: start held high through the DONE cycle gives the next done WIDTH+2 cycles later. No idle gap is required.
- Simultaneous reset and start: reset wins.

## Structure
- Package div_pkg holds:
  - state encoding localparams (IDLE=0, CALC=1, FIX=2, DONE=3)
  - the default WIDTH
  - a helper function for two's-complement magnitude
- One sub-module, div_step: a combinational single restoring iteration.
  - Inputs: P, next bit, |divisor|.
  - Outputs: new P, quotient bit.
  - It is reused by a future unrolled/pipelined divider.
- Counter width: clog2(WIDTH+1).

## Test plan
- WIDTH=6, SIGNED=1, 27 ÷ 5 → q=5, r=2, done exactly 8 cycles after start, busy high 7 cycles.
- −27 ÷ 5 → q=−5 (6'b111011), r=−2 (6'b111110); 27 ÷ −5 → q=−5, r=2; −27 ÷ −5 → q=5, r=−2.
- 13 ÷ 0 → q=6'b111111, r=13, dbz=1, done 2 cycles after start; next valid op clears dbz.
- −32 ÷ −1 → q=−32 (6'b100000), r=0, ovf=1. With SIGNED=0: 63 ÷ 7 → q=9, r=0; 5 ÷ 9 → q=0, r=5.
- start pulsed at cycles 3 and 5 of an op → second ignored, single done; start held through DONE → second op's done 8 cycles later, results correct.
- Reset asserted at CALC cycle 4 → next cycle IDLE, all outputs 0, no done pulse; a fresh op afterwards completes correctly.
